// File: rtl/digit_serial_adder_pkg.sv
// rtl/digit_serial_adder_pkg.sv - shared state encoding and sizing helper for the digit-serial adder
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; a single-digit configuration still needs one bit.
    function automatic int cnt_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple adder exposing carry into and out of its MSB
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin : ripple
        logic [DIGIT:0] c;
        c     = '0;
        sum   = '0;
        c[0]  = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout  = c[DIGIT];
        c_msb = c[DIGIT-1];
    end

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - WIDTH-bit adder/subtractor processing DIGIT bits per clock, LSD first
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CW         = cnt_width(NUM_DIGITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DIGITS - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] d;
    logic             c;
    logic             c_msb;
    logic [WIDTH-1:0] next_sum;

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit_adder (
        .a    (a_reg[DIGIT-1:0]),
        .b    (b_reg[DIGIT-1:0]),
        .cin  (carry),
        .sum  (d),
        .cout (c),
        .c_msb(c_msb)
    );

    // New digit enters at the top so after NUM_DIGITS shifts the result is aligned.
    assign next_sum = (sum_reg >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= sub ? ~b : b;
                        carry   <= sub ? 1'b1 : carry_in;
                        cnt     <= LAST_CNT;
                        sum_reg <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_reg <= next_sum;
                    a_reg   <= a_reg >> DIGIT;
                    b_reg   <= b_reg >> DIGIT;
                    carry   <= c;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        sum       <= next_sum;
                        carry_out <= c;
                        overflow  <= c ^ c_msb;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - scoreboard bench for DIGIT=4, 1 and 16 instances of digit_serial_adder
module tb_digit_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        carry_in = 1'b0;
    logic        start_q [3];
    logic [15:0] sum_o   [3];
    logic        co_o    [3];
    logic        ov_o    [3];
    logic        busy_o  [3];
    logic        done_o  [3];

    exp_t        sb [0:2][$];
    logic [15:0] last_sum [3];
    logic        last_co  [3];
    logic        last_ov  [3];
    int          nd [3] = '{4, 16, 1};
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(reset), .start(start_q[0]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .sum(sum_o[0]), .carry_out(co_o[0]), .overflow(ov_o[0]),
        .busy(busy_o[0]), .done(done_o[0]));

    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start_q[1]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .sum(sum_o[1]), .carry_out(co_o[1]), .overflow(ov_o[1]),
        .busy(busy_o[1]), .done(done_o[1]));

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .reset(reset), .start(start_q[2]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .sum(sum_o[2]), .carry_out(co_o[2]), .overflow(ov_o[2]),
        .busy(busy_o[2]), .done(done_o[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks hold behaviour while idle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                sb[i].delete();
                last_sum[i] = '0;
                last_co[i]  = 1'b0;
                last_ov[i]  = 1'b0;
            end else if (done_o[i]) begin
                if (sb[i].size() == 0) begin
                    check($sformatf("unexpected_done[%0d]", i), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb[i].pop_front();
                    check($sformatf("sum[%0d]", i), 32'(sum_o[i]), 32'(e.sum));
                    check($sformatf("carry_out[%0d]", i), 32'(co_o[i]), 32'(e.co));
                    check($sformatf("overflow[%0d]", i), 32'(ov_o[i]), 32'(e.ov));
                    check($sformatf("latency[%0d]", i), 32'(cyc), 32'(e.done_cyc));
                    last_sum[i] = e.sum;
                    last_co[i]  = e.co;
                    last_ov[i]  = e.ov;
                end
            end else if (!busy_o[i]) begin
                check($sformatf("hold_sum[%0d]", i), 32'(sum_o[i]), 32'(last_sum[i]));
                check($sformatf("hold_flags[%0d]", i), {30'd0, co_o[i], ov_o[i]},
                      {30'd0, last_co[i], last_ov[i]});
            end
        end
    end

    task automatic wait_idle(input int idx);
        int n = 0;
        @(negedge clk);
        while (busy_o[idx] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy_o[idx]) check($sformatf("idle_timeout[%0d]", idx), 32'd1, 32'd0);
    endtask

    function automatic exp_t model(input logic s, input logic [15:0] av, input logic [15:0] bv,
                                   input logic ci);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] full;
        bb      = s ? ~bv : bv;
        full    = {1'b0, av} + {1'b0, bb} + 17'(s ? 1'b1 : ci);
        e.sum   = full[15:0];
        e.co    = full[16];
        e.ov    = (av[15] == bb[15]) && (full[15] != av[15]);
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic issue(input int idx, input logic s, input logic [15:0] av,
                         input logic [15:0] bv, input logic ci);
        exp_t e;
        wait_idle(idx);
        sub = s; a = av; b = bv; carry_in = ci;
        start_q[idx] = 1'b1;
        e = model(s, av, bv, ci);
        @(posedge clk);
        #1;
        start_q[idx] = 1'b0;
        e.done_cyc = cyc + nd[idx];
        sb[idx].push_back(e);
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic issue_all(input logic s, input logic [15:0] av, input logic [15:0] bv,
                             input logic ci);
        for (int i = 0; i < 3; i++) issue(i, s, av, bv, ci);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_sum[%0d]", tag, i), 32'(sum_o[i]), 32'd0);
            check($sformatf("%s_ctl[%0d]", tag, i),
                  {28'd0, co_o[i], ov_o[i], busy_o[i], done_o[i]}, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) start_q[i] = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed vectors on all three digit widths.
        issue_all(1'b0, 16'h00FF, 16'h0001, 1'b0);
        issue_all(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        issue_all(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        issue_all(1'b0, 16'h1234, 16'h1111, 1'b1);
        issue_all(1'b1, 16'h0005, 16'h0007, 1'b0);
        issue_all(1'b1, 16'h8000, 16'h0001, 1'b1);

        // start held through RUN/DONE with operands changing: one result, busy for 5 cycles.
        begin
            exp_t e;
            int   busy_cnt = 0;
            wait_idle(0);
            sub = 1'b0; a = 16'h4321; b = 16'h1234; carry_in = 1'b0;
            start_q[0] = 1'b1;
            e = model(1'b0, 16'h4321, 16'h1234, 1'b0);
            @(posedge clk);
            #1;
            e.done_cyc = cyc + 4;
            sb[0].push_back(e);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (busy_o[0]) busy_cnt++;
                a = 16'($urandom);
                b = 16'($urandom);
                carry_in = 1'($urandom);
                if (done_o[0]) start_q[0] = 1'b0;
            end
            start_q[0] = 1'b0;
            check("busy_cycles", 32'(busy_cnt), 32'd5);
        end

        // Asynchronous reset during the second RUN cycle.
        wait_idle(0);
        sub = 1'b0; a = 16'h0F0F; b = 16'h0101; carry_in = 1'b0;
        start_q[0] = 1'b1;
        @(posedge clk);
        #1 start_q[0] = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        issue_all(1'b0, 16'h0F0F, 16'h0101, 1'b1);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            issue_all(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        begin
            int n = 0;
            while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            check("drain", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
